uart_tx_param: RTL
==================

Name: uart_tx_param

Overview:
- Parametrised, single-clock UART transmitter. Successor to the fixed 8-bit transmitter.
- Accepts parallel words through a valid/ready handshake into an internal FIFO and serialises them LSB-first on one line.
- Frame: start bit, DATA_W data bits, optional odd/even parity bit, then 1 or 2 stop bits.
- The baud rate comes from a runtime divisor that drives a clock-enable. There is no derived clock.
- Sits between the bus-side producer and the TX pad.

Parameters:
- DATA_W, 8, data bits per frame; legal range 5..9.
- FIFO_DEPTH, 4, input FIFO entries; power of two, >=2.
- DIV_W, 16, width of the baud divisor input.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- baud_div  input  DIV_W  clock cycles per bit minus 1; 0 = one cycle per bit.
- parity_type  input  2  00 none, 01 odd, 10 even, 11 none.
- stop2  input  1  1 = two stop bits, 0 = one.
- data_in  input  DATA_W  word to transmit.
- data_valid  input  1  producer has a word.
- data_ready  output  1  FIFO can accept a word (= not full).
- data_out  output  1  serial line, idle high.
- tx_active  output  1  high while a frame is on the line.
- tx_done  output  1  one-cycle pulse at the end of each frame.
- fifo_count  output  clog2(FIFO_DEPTH+1)  words currently queued.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: data_out=1, tx_active=0, tx_done=0, data_ready=1, fifo_count=0.
  - FIFO is flushed, FSM goes to IDLE, counters clear.
  - Reset mid-frame aborts the frame immediately; the line goes high in the same reset assertion.
- Push and pop rules:
  - Push happens on an edge with data_valid && data_ready.
  - Full FIFO: data_ready=0 and the word is not taken.
  - Push and pop on the same edge leave fifo_count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If the FIFO is non-empty, pop the head on the next edge.
  - On that edge, latch the word, baud_div, parity_type and stop2 into frame registers, then go to START.
  - Config inputs are sampled only here. Changes mid-frame take effect on the next frame.
- Latency: a word pushed into an empty FIFO while IDLE drives data_out low one cycle after the accepting edge.
- Bit timing: every bit lasts exactly baud_div+1 cycles. A divisor counter loads baud_div at each bit start and the bit ends when it reaches 0.
- START: data_out=0 for one bit, then go to DATA.
- DATA:
  - data_out carries word[i] for i=0..DATA_W-1, LSB first.
  - After the last bit, go to PARITY if parity is enabled, else STOP.
- PARITY:
  - Even: bit = XOR of the data bits.
  - Odd: bit = inverted XOR of the data bits.
  - Lasts one bit.
- STOP: data_out=1 for 1 or 2 bits, per the latched stop2.
- Frame end:
  - tx_done pulses on the final cycle of the last stop bit.
  - Next state is START (no idle gap) if the FIFO is non-empty at that cycle; the pop and latch happen on that edge. Otherwise next state is IDLE.
- tx_active: high from the first START cycle through the last STOP cycle. It stays high across back-to-back frames.
- Frame length in bits: 1 + DATA_W + (parity ? 1 : 0) + (stop2 ? 2 : 1).
- data_out is registered and glitch-free, and is high in IDLE.

Test Plan:
1. DATA_W=8, baud_div=3, parity 00, stop2=0, push 0xA5 -> data_out bits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. tx_done pulses on cycle 40 of the frame, then IDLE with data_out=1.
2. Same word, parity 10, then 01, stop2=1 -> 12-bit frames. Parity bit is 0 (even) and 1 (odd). Two stop bits, 48 cycles total.
3. baud_div=15, push 6 words on consecutive cycles -> exactly 5 accepted. data_ready=0 while fifo_count=4. Frames go out back-to-back with no idle cycles and tx_active held high.
4. Change baud_div from 3 to 7 mid-frame -> current frame keeps 4-cycle bits; next frame uses 8-cycle bits.
5. Assert rst in the middle of DATA with 2 words queued -> data_out=1, tx_active=0, fifo_count=0 immediately. No tx_done pulse. After release the line stays idle.
6. baud_div=0, DATA_W=5, push 0x1F -> 7-cycle frame 0,1,1,1,1,1,1. tx_done pulses on cycle 7.

Source files
------------

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised FIFO-fed UART transmitter
//
// Purpose: queues parallel words through a valid/ready handshake and sends
// each one LSB-first as start bit, DATA_W data bits, optional parity bit and
// one or two stop bits. Bit timing comes from a clock-enable divisor; no
// derived clock is used.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   baud_div     clock cycles per bit minus 1 (sampled at frame start)
//   parity_type  00/11 none, 01 odd, 10 even (sampled at frame start)
//   stop2        1 = two stop bits (sampled at frame start)
//   data_in      word to queue, accepted when data_valid && data_ready
//   data_ready   FIFO not full
//   data_out     registered serial line, idle high
//   tx_active    high while a frame is on the line
//   tx_done      one-cycle pulse on the final cycle of each frame
//   fifo_count   words currently queued
module uart_tx_param #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16,
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        parity_type,
  input  logic              stop2,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              data_out,
  output logic              tx_active,
  output logic              tx_done,
  output logic [CNT_W-1:0]  fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push, load, fifo_empty;

  // Per-frame copies of the word and configuration
  logic [DATA_W-1:0] word_q;
  logic [DIV_W-1:0]  div_q;
  logic [1:0]        par_q;
  logic              stop2_q;

  logic [DIV_W-1:0]  div_cnt, div_n;
  logic [BW-1:0]     bit_idx, bit_n;
  logic              stop_idx, stop_n;
  logic              bit_end, frame_end, par_en, par_bit, out_n;

  assign fifo_empty = (count == '0);
  assign data_ready = (count != CNT_W'(FIFO_DEPTH));
  assign push       = data_valid && data_ready;
  assign fifo_count = count;

  assign par_en    = (par_q == 2'b01) || (par_q == 2'b10);
  assign par_bit   = (^word_q) ^ (par_q == 2'b01);
  assign bit_end   = (div_cnt == '0);
  assign frame_end = (state == STOP) && bit_end && (stop_idx || !stop2_q);
  assign tx_done   = frame_end;
  assign tx_active = (state != IDLE);

  always_comb begin
    state_n = state;
    bit_n   = bit_idx;
    stop_n  = stop_idx;
    div_n   = bit_end ? div_cnt : div_cnt - DIV_W'(1);
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          load    = 1'b1;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          bit_n   = '0;
          div_n   = div_q;
        end
      end
      DATA: begin
        if (bit_end) begin
          div_n = div_q;
          if (bit_idx == BW'(DATA_W - 1)) begin
            state_n = par_en ? PARITY : STOP;
            stop_n  = 1'b0;
          end else begin
            bit_n = bit_idx + BW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          stop_n  = 1'b0;
          div_n   = div_q;
        end
      end
      STOP: begin
        if (frame_end) begin
          // Chain straight into the next frame when a word is waiting
          if (!fifo_empty) begin
            load    = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else if (bit_end) begin
          stop_n = 1'b1;
          div_n  = div_q;
        end
      end
      default: state_n = IDLE;
    endcase
    // The start bit runs on the freshly sampled divisor, not the old frame's
    if (load) div_n = baud_div;
  end

  // Line value is decoded from the next state so data_out is a plain register
  always_comb begin
    out_n = 1'b1;
    case (state_n)
      START:   out_n = 1'b0;
      DATA:    out_n = word_q[bit_n];
      PARITY:  out_n = par_bit;
      default: out_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      data_out <= 1'b1;
      word_q   <= '0;
      div_q    <= '0;
      par_q    <= 2'b00;
      stop2_q  <= 1'b0;
    end else begin
      state    <= state_n;
      div_cnt  <= div_n;
      bit_idx  <= bit_n;
      stop_idx <= stop_n;
      data_out <= out_n;
      if (load) begin
        word_q  <= mem[rd_ptr];
        div_q   <= baud_div;
        par_q   <= parity_type;
        stop2_q <= stop2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) rd_ptr <= rd_ptr + AW'(1);
      case ({push, load})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

endmodule
